seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered ALU for the multi-cycle datapath.
- Same op encoding for the base ops, widened to a 4-bit ALUOp.
- Adds shift-left, signed and unsigned compare, and an iterative shift-add multiplier.
- Uses a start/busy/done handshake so the controller can stall on multi-cycle ops; the result is held in an output register.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only when busy=0
- ALUOp  in  4  operation select, sampled with start
- A  in  WIDTH  operand A, sampled with start
- B  in  WIDTH  operand B, sampled with start
- busy  out  1  high while a multiply is iterating
- done  out  1  one-cycle pulse; C valid from this cycle on
- C  out  WIDTH  result register, held until the next done
- zero  out  1  registered (C == 0), updated with C

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: on a clk edge with reset=1:
  - C=0, zero=1, busy=0, done=0, state=IDLE, iteration counter=0.
  - Reset overrides start and aborts any multiply in progress; no done is issued for the aborted op.
- ALUOp encoding:
  - 0000 A+B
  - 0001 A-B
  - 0010 A&B
  - 0011 A|B
  - 0100 A>>sh (logical)
  - 0101 $signed(A)>>>sh (arithmetic)
  - 0110 A<<sh
  - 0111 slt: 1 if $signed(A)<$signed(B), else 0
  - 1000 sltu: unsigned compare, result 1/0
  - 1001 mul: low WIDTH bits of A*B
  - 1010..1111: C=0
- Shift amount: sh = B[SHW-1:0]; upper bits of B are ignored. Add/sub wrap modulo 2^WIDTH.
- States: IDLE, MUL.
- IDLE:
  - start=1 with a non-mul op at edge k: C and zero updated at edge k; done=1 for the cycle after edge k; state stays IDLE; busy stays 0. Latency is 1 cycle.
  - start=1 with mul at edge k:
    - Latch A into mcand, B into mplier; clear acc; cnt=WIDTH.
    - busy=1 from edge k; state goes to MUL. C and zero hold their old values.
- MUL, each edge:
  - If mplier[0], acc += mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt -= 1.
  - On the edge where cnt goes 1→0:
    - C = final acc; zero updated.
    - done=1 for the following cycle; busy=0; state goes to IDLE.
  - Mul latency is WIDTH cycles: start at edge k gives done after edge k+WIDTH.
- Start acceptance:
  - start is ignored while busy=1. Operands are latched, so A/B/ALUOp may change freely during MUL.
  - start in the same cycle as done (busy=0) is accepted, so back-to-back issue has no bubble.
- done is low in every cycle not explicitly listed above; done never stays high 2 cycles unless back-to-back ops are issued.

Optional Feature:
- Macro: SEQ_ALU_OVERFLOW_EN.
- Defined:
  - Extra output port overflow (out, 1), reset to 0, updated only when C is updated.
  - ALUOp 0000: overflow = signed add overflow (A[MSB]==B[MSB] && C[MSB]!=A[MSB]).
  - ALUOp 0001: overflow = signed sub overflow (A[MSB]!=B[MSB] && C[MSB]!=A[MSB]).
  - All other ops: overflow = 0.
- Undefined: no overflow port; the rest of the behaviour is identical.

Test Plan:
- Reset with WIDTH=32: assert reset during a mul at iteration 5 → next cycle busy=0, done=0, C=0, zero=1; no done pulse appears afterwards.
- Single-cycle ops: start with ALUOp=0001, A=5, B=7 → after 1 edge, done=1, C=0xFFFFFFFE, zero=0. Then ALUOp=0101, A=0x80000000, B=0x24 (sh=4) → C=0xF8000000.
- Compares: ALUOp=0111, A=0xFFFFFFFF, B=1 → C=1. ALUOp=1000 with the same operands → C=0. ALUOp=1100 → C=0, zero=1.
- Multiply:
  - start with ALUOp=1001, A=0x12345, B=0x100 → busy=1 for exactly 32 cycles; done after edge k+32; C=0x01234500.
  - A=0xFFFFFFFF, B=0xFFFFFFFF → C=1.
  - Mid-op start=1 with ALUOp=0000 is ignored.
- Back-to-back: start a mul, then assert start (add, A=1, B=2) in the done cycle → add accepted; C=3 with done one cycle later; mul result seen on C for exactly one cycle.
- With SEQ_ALU_OVERFLOW_EN: ALUOp=0000, A=0x7FFFFFFF, B=1 → C=0x80000000, overflow=1. ALUOp=0001, A=0x80000000, B=1 → overflow=1. ALUOp=0010 → overflow=0.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with an iterative shift-add multiplier.
// Define SEQ_ALU_OVERFLOW_EN to add the signed add/sub overflow output.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic             zero
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] c_q;
    logic             zero_q;
    logic             done_q;
    logic             busy_q;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_d;
    logic [WIDTH-1:0] acc_d;
    logic             is_mul;
    logic             slt_bit;
    logic             sltu_bit;

    assign sh       = B[SHW-1:0];
    assign sum      = A + B;
    assign diff     = A - B;
    assign is_mul   = (ALUOp == OP_MUL);
    assign slt_bit  = ($signed(A) < $signed(B));
    assign sltu_bit = (A < B);

    // Single-cycle result for every non-multiply op.
    always_comb begin
        alu_d = '0;
        case (ALUOp)
            OP_ADD:  alu_d = sum;
            OP_SUB:  alu_d = diff;
            OP_AND:  alu_d = A & B;
            OP_OR:   alu_d = A | B;
            OP_SRL:  alu_d = A >> sh;
            OP_SRA:  alu_d = $unsigned($signed(A) >>> sh);
            OP_SLL:  alu_d = A << sh;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, sltu_bit};
            default: alu_d = '0;
        endcase
    end

    // One shift-add step: accumulate the shifted multiplicand on a set bit.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

`ifdef SEQ_ALU_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow is only meaningful for add and subtract.
    always_comb begin
        ovf_d = 1'b0;
        case (ALUOp)
            OP_ADD: ovf_d = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            OP_SUB: ovf_d = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            default: ovf_d = 1'b0;
        endcase
    end

    assign overflow = ovf_q;
`endif

    // Control FSM: issue, multiply iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            c_q      <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (is_mul) begin
                            mcand_q  <= A;
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= CW'(WIDTH);
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else begin
                            c_q    <= alu_d;
                            zero_q <= (alu_d == '0);
                            done_q <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
                            ovf_q  <= ovf_d;
`endif
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    done_q   <= 1'b0;
                    if (cnt_q == CW'(1)) begin
                        c_q     <= acc_d;
                        zero_q  <= (acc_d == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`ifdef SEQ_ALU_OVERFLOW_EN
                        ovf_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign C    = c_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven and scoreboard checks for seq_alu.
// Overflow checks are included when SEQ_ALU_OVERFLOW_EN is defined.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] c;
    logic         zero;
`ifdef SEQ_ALU_OVERFLOW_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ALUOp    (op),
        .A        (a),
        .B        (b),
        .busy     (busy),
        .done     (done),
        .C        (c),
`ifdef SEQ_ALU_OVERFLOW_EN
        .zero     (zero),
        .overflow (ovf)
`else
        .zero     (zero)
`endif
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         z;
        logic         v;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, " C"}, c, e.c);
                chk({e.name, " zero"}, W'(zero), W'(e.z));
`ifdef SEQ_ALU_OVERFLOW_EN
                chk({e.name, " ovf"}, W'(ovf), W'(e.v));
`endif
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] ec,
                         input logic ev, input string nm);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sbq.push_back('{c: ec, z: (ec == '0), v: ev, name: nm});
        @(posedge clk);
        #1;
    endtask

    task automatic mul_run(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic mid, input string nm);
        int           cyc;
        logic [W-1:0] e;
        cyc = 0;
        e   = x * y;
        issue(4'b1001, x, y, e, 1'b0, nm);
        start = 1'b0;
        while (busy === 1'b1 && cyc < 200) begin
            if (mid && cyc == 4) begin
                start = 1'b1;
                op    = 4'b0000;
                a     = 32'h1;
                b     = 32'h2;
            end else if (mid && cyc == 6) begin
                start = 1'b0;
                a     = 32'hDEAD_BEEF;
                b     = 32'h0BAD_F00D;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        chk({nm, " busy_cycles"}, W'(cyc), W'(32));
        chk({nm, " done"}, W'(done), W'(1));
    endtask

    vec_t tbl[15];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        tbl[0]  = '{op: 4'b0001, a: 32'd5,          b: 32'd7,
                    c: 32'hFFFF_FFFE, v: 1'b0};
        tbl[1]  = '{op: 4'b0101, a: 32'h8000_0000, b: 32'h24,
                    c: 32'hF800_0000, v: 1'b0};
        tbl[2]  = '{op: 4'b0111, a: 32'hFFFF_FFFF, b: 32'h1,
                    c: 32'h1,         v: 1'b0};
        tbl[3]  = '{op: 4'b1000, a: 32'hFFFF_FFFF, b: 32'h1,
                    c: 32'h0,         v: 1'b0};
        tbl[4]  = '{op: 4'b1100, a: 32'h1234_5678, b: 32'h9,
                    c: 32'h0,         v: 1'b0};
        tbl[5]  = '{op: 4'b0000, a: 32'hFFFF_FFFF, b: 32'h1,
                    c: 32'h0,         v: 1'b0};
        tbl[6]  = '{op: 4'b0010, a: 32'h0000_F0F0, b: 32'h0000_FF00,
                    c: 32'h0000_F000, v: 1'b0};
        tbl[7]  = '{op: 4'b0011, a: 32'h0F,        b: 32'hF0,
                    c: 32'hFF,        v: 1'b0};
        tbl[8]  = '{op: 4'b0100, a: 32'h8000_0000, b: 32'h21,
                    c: 32'h4000_0000, v: 1'b0};
        tbl[9]  = '{op: 4'b0110, a: 32'h1,         b: 32'hFFFF_FFFF,
                    c: 32'h8000_0000, v: 1'b0};
        tbl[10] = '{op: 4'b0111, a: 32'h1,         b: 32'hFFFF_FFFF,
                    c: 32'h0,         v: 1'b0};
        tbl[11] = '{op: 4'b1000, a: 32'h1,         b: 32'hFFFF_FFFF,
                    c: 32'h1,         v: 1'b0};
        tbl[12] = '{op: 4'b0000, a: 32'h7FFF_FFFF, b: 32'h1,
                    c: 32'h8000_0000, v: 1'b1};
        tbl[13] = '{op: 4'b0001, a: 32'h8000_0000, b: 32'h1,
                    c: 32'h7FFF_FFFF, v: 1'b1};
        tbl[14] = '{op: 4'b1111, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF,
                    c: 32'h0,         v: 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset C", c, 32'h0);
        chk("reset zero", W'(zero), W'(1));
        chk("reset busy", W'(busy), W'(0));
        chk("reset done", W'(done), W'(0));
`ifdef SEQ_ALU_OVERFLOW_EN
        chk("reset ovf", W'(ovf), W'(0));
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].v,
                  $sformatf("vec%0d", i));
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("table drained", W'(sbq.size()), W'(0));
        chk("idle done low", W'(done), W'(0));

        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_00A5, 32'hA5, 1'b0, "and");
        start = 1'b0;
        mul_run(32'h0001_2345, 32'h0000_0100, 1'b1, "mul_mid");
        chk("mul C", c, 32'h0123_4500);
        mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_ones");
        chk("mul ones C", c, 32'h1);
        mul_run(32'hCAFE_0001, 32'h0, 1'b0, "mul_zero");
        for (int i = 0; i < 3; i++) begin
            mul_run($urandom, $urandom, 1'b0, $sformatf("mul_rnd%0d", i));
        end

        mul_run(32'd3, 32'd5, 1'b0, "b2b_mul");
        chk("b2b mul C", c, 32'd15);
        issue(4'b0000, 32'd1, 32'd2, 32'd3, 1'b0, "b2b_add");
        start = 1'b0;
        chk("b2b add done", W'(done), W'(1));
        chk("b2b add C", c, 32'd3);
        @(posedge clk);
        #1;
        chk("b2b done drop", W'(done), W'(0));
        chk("b2b drained", W'(sbq.size()), W'(0));

        issue(4'b1001, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0,
              "abort");
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort busy before", W'(busy), W'(1));
        reset = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort busy", W'(busy), W'(0));
        chk("abort done", W'(done), W'(0));
        chk("abort C", c, 32'h0);
        chk("abort zero", W'(zero), W'(1));
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        chk("abort no done", W'(nd), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
